// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - shares one UART transmitter between sensor-report and ack frames
module uart_frame_scheduler #(
  parameter int unsigned REPORT_PERIOD_CYC = 100_000_000
) (
  input  logic       clk_100Mhz,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] temperature,
  input  logic [7:0] humidity,
  input  logic       ack_req,
  input  logic [1:0] ack_code,
  input  logic       uart_tx_active,
  input  logic       uart_tx_done,
  output logic       uart_send,
  output logic [7:0] uart_data,
  output logic       frame_done,
  output logic       frame_id,
  output logic       report_pending,
  output logic       ack_pending,
  output logic [7:0] drop_cnt
);

  localparam int TW = $clog2(REPORT_PERIOD_CYC);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REPORT_PERIOD_CYC - 1);
  localparam logic FRAME_SENSOR = 1'b0;
  localparam logic FRAME_ACK    = 1'b1;

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_DONE, FINISH} state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic          tick;
  logic [1:0]    ack_code_q;
  logic          last_served;
  logic [7:0]    frame_buf [6];
  logic [2:0]    frame_last_idx;
  logic [2:0]    byte_idx;
  logic          grant_sensor;
  logic          grant_ack;
  logic [6:0]    t_clamp;
  logic [6:0]    h_clamp;

  function automatic logic [7:0] ascii_digit(input logic [6:0] v);
    return 8'h30 + {1'b0, v};
  endfunction

  assign tick    = enable && (timer == TIMER_LAST);
  assign t_clamp = (temperature > 8'd99) ? 7'd99 : temperature[6:0];
  assign h_clamp = (humidity > 8'd99) ? 7'd99 : humidity[6:0];

  // On a tie the frame type not served last wins; last_served resets to ack.
  always_comb begin
    grant_sensor = 1'b0;
    grant_ack    = 1'b0;
    if (state == IDLE) begin
      if (report_pending && (!ack_pending || last_served == FRAME_ACK))
        grant_sensor = 1'b1;
      else if (ack_pending)
        grant_ack = 1'b1;
    end
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!rst_n) begin
      state          <= IDLE;
      timer          <= '0;
      report_pending <= 1'b0;
      ack_pending    <= 1'b0;
      ack_code_q     <= 2'b00;
      drop_cnt       <= 8'd0;
      last_served    <= FRAME_ACK;
      frame_last_idx <= 3'd0;
      byte_idx       <= 3'd0;
      uart_send      <= 1'b0;
      uart_data      <= 8'h00;
      frame_done     <= 1'b0;
      frame_id       <= FRAME_SENSOR;
      for (int i = 0; i < 6; i++) frame_buf[i] <= 8'h00;
    end else begin
      uart_send  <= 1'b0;
      frame_done <= 1'b0;

      if (!enable || tick) timer <= '0;
      else                 timer <= timer + TW'(1);

      // A new request in the grant cycle outranks the clear.
      if (tick) begin
        report_pending <= 1'b1;
        if (report_pending && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (grant_sensor) begin
        report_pending <= 1'b0;
      end

      if (ack_req) begin
        ack_pending <= 1'b1;
        ack_code_q  <= ack_code;
      end else if (grant_ack) begin
        ack_pending <= 1'b0;
      end

      unique case (state)
        IDLE: begin
          if (grant_sensor) begin
            frame_buf[0]   <= 8'h53;
            frame_buf[1]   <= ascii_digit(t_clamp / 7'd10);
            frame_buf[2]   <= ascii_digit(t_clamp % 7'd10);
            frame_buf[3]   <= ascii_digit(h_clamp / 7'd10);
            frame_buf[4]   <= ascii_digit(h_clamp % 7'd10);
            frame_buf[5]   <= 8'h0A;
            frame_last_idx <= 3'd5;
            frame_id       <= FRAME_SENSOR;
            state          <= LOAD;
          end else if (grant_ack) begin
            frame_buf[0]   <= 8'h41;
            frame_buf[1]   <= 8'h3A;
            frame_buf[2]   <= 8'h30 + {7'd0, ack_code_q[1]};
            frame_buf[3]   <= 8'h30 + {7'd0, ack_code_q[0]};
            frame_buf[4]   <= 8'h0A;
            frame_buf[5]   <= 8'h00;
            frame_last_idx <= 3'd4;
            frame_id       <= FRAME_ACK;
            state          <= LOAD;
          end
        end
        LOAD: begin
          byte_idx <= 3'd0;
          if (!uart_tx_active) begin
            uart_send <= 1'b1;
            uart_data <= frame_buf[0];
            state     <= WAIT_DONE;
          end else begin
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (!uart_tx_active) begin
            uart_send <= 1'b1;
            uart_data <= frame_buf[byte_idx];
            state     <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          // Issue the next byte straight away when the transmitter is already free.
          if (uart_tx_done) begin
            if (byte_idx == frame_last_idx) begin
              frame_done  <= 1'b1;
              last_served <= frame_id;
              state       <= FINISH;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              if (!uart_tx_active) begin
                uart_send <= 1'b1;
                uart_data <= frame_buf[byte_idx + 3'd1];
              end else begin
                state <= ISSUE;
              end
            end
          end
        end
        FINISH: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - directed and randomized bench for uart_frame_scheduler
module tb_uart_frame_scheduler;

  localparam int P = 200;
  localparam int BYTE_CYC = 20;
  localparam int SAT_PERIODS = 260;

  logic       clk_100Mhz = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] temperature = 8'd0;
  logic [7:0] humidity = 8'd0;
  logic       ack_req = 1'b0;
  logic [1:0] ack_code = 2'b00;
  logic       uart_tx_active = 1'b0;
  logic       uart_tx_done = 1'b0;
  logic       uart_send;
  logic [7:0] uart_data;
  logic       frame_done;
  logic       frame_id;
  logic       report_pending;
  logic       ack_pending;
  logic [7:0] drop_cnt;

  uart_frame_scheduler #(.REPORT_PERIOD_CYC(P)) dut (
    .clk_100Mhz    (clk_100Mhz),
    .rst_n         (rst_n),
    .enable        (enable),
    .temperature   (temperature),
    .humidity      (humidity),
    .ack_req       (ack_req),
    .ack_code      (ack_code),
    .uart_tx_active(uart_tx_active),
    .uart_tx_done  (uart_tx_done),
    .uart_send     (uart_send),
    .uart_data     (uart_data),
    .frame_done    (frame_done),
    .frame_id      (frame_id),
    .report_pending(report_pending),
    .ack_pending   (ack_pending),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] rx_q[$];
  logic       fd_q[$];
  logic [7:0] exp_q[$];
  logic       exp_id[$];
  int         rx_rd = 0;
  int         fd_rd = 0;
  int         n_sends = 0;
  int         send_busy = 0;
  int         unstable = 0;
  int         busy = 0;
  bit         stall = 1'b0;
  logic [7:0] cur_byte = 8'h00;

  // Byte-level transmitter stand-in: BYTE_CYC cycles per byte, done withheld while stalled.
  initial begin : uart_model
    forever begin
      @(negedge clk_100Mhz);
      uart_tx_done = 1'b0;
      if (!rst_n) begin
        uart_tx_active = 1'b0;
        busy = 0;
      end else begin
        if (frame_done) fd_q.push_back(frame_id);
        if (uart_send) begin
          n_sends++;
          if (uart_tx_active) send_busy++;
          rx_q.push_back(uart_data);
          cur_byte = uart_data;
          uart_tx_active = 1'b1;
          busy = BYTE_CYC;
        end else if (uart_tx_active) begin
          if (uart_data !== cur_byte) unstable++;
          if (busy > 1) busy--;
          else if (!stall) begin
            uart_tx_active = 1'b0;
            uart_tx_done = 1'b1;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk_100Mhz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_sensor(input int t, input int h);
    string s;
    s = $sformatf("S%02d%02d\n", (t > 99) ? 99 : t, (h > 99) ? 99 : h);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_id.push_back(1'b0);
  endtask

  task automatic exp_ack(input logic [1:0] c);
    string s;
    s = $sformatf("A:%0d%0d\n", c[1], c[0]);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    exp_id.push_back(1'b1);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int c;
    c = 0;
    while (fd_q.size() < fd_rd + n && c < budget) begin
      step();
      c++;
    end
    check("frame_wait", 32'(fd_q.size() >= fd_rd + n), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_byte_count"}, rx_q.size() - rx_rd, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (rx_rd + i < rx_q.size()) check({tag, "_byte"}, 32'(rx_q[rx_rd + i]), 32'(exp_q[i]));
    check({tag, "_frame_count"}, fd_q.size() - fd_rd, exp_id.size());
    for (int i = 0; i < exp_id.size(); i++)
      if (fd_rd + i < fd_q.size()) check({tag, "_frame_id"}, 32'(fd_q[fd_rd + i]), 32'(exp_id[i]));
    rx_rd = rx_q.size();
    fd_rd = fd_q.size();
    exp_q.delete();
    exp_id.delete();
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    stall = 1'b0;
    step();
    check("rst_uart_send", 32'(uart_send), 32'd0);
    check("rst_uart_data", 32'(uart_data), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_id", 32'(frame_id), 32'd0);
    check("rst_report_pending", 32'(report_pending), 32'd0);
    check("rst_ack_pending", 32'(ack_pending), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    rx_rd = rx_q.size();
    fd_rd = fd_q.size();
    exp_q.delete();
    exp_id.delete();
  endtask

  // One report period from a cold timer; optionally an ack request lands on the terminal count.
  task automatic run_tick(input bit with_ack, input logic [1:0] code);
    int first_pend;
    int first_send;
    int base;
    first_pend = -1;
    first_send = -1;
    base = n_sends;
    enable = 1'b1;
    for (int i = 1; i <= P + 3; i++) begin
      step();
      if (report_pending && first_pend < 0) first_pend = i;
      if (n_sends > base && first_send < 0) first_send = i;
      ack_req = with_ack && (i == P - 1);
      ack_code = code;
      if (i == P) enable = 1'b0;
    end
    check("pending_latency", first_pend, P);
    check("send_latency", first_send, P + 2);
  endtask

  initial begin : stimulus
    int t;
    int h;
    int exp_drop;
    int base;
    int fd_base;
    int c;
    logic [1:0] rc;

    repeat (2) step();
    pulse_reset();

    // first tie after reset: sensor frame wins
    temperature = 8'd25;
    humidity = 8'd50;
    exp_sensor(25, 50);
    exp_ack(2'b10);
    run_tick(1'b1, 2'b10);
    check("tie1_ack_pending", 32'(ack_pending), 32'd1);
    wait_frames(2, 2000);
    check_stream("tie1");

    // clamp and capture at grant
    temperature = 8'd123;
    humidity = 8'd7;
    exp_sensor(123, 7);
    run_tick(1'b0, 2'b00);
    temperature = 8'd30;
    wait_frames(1, 2000);
    check_stream("clamp");

    // random ack-only frames, then random sensor frames
    for (int k = 0; k < 2; k++) begin
      rc = 2'($urandom_range(0, 3));
      exp_ack(rc);
      ack_req = 1'b1;
      ack_code = rc;
      step();
      ack_req = 1'b0;
      check("ack_only_pending", 32'(ack_pending), 32'd1);
      wait_frames(1, 2000);
      check_stream("ack_only");
    end
    for (int k = 0; k < 3; k++) begin
      t = $urandom_range(0, 255);
      h = $urandom_range(0, 255);
      temperature = 8'(t);
      humidity = 8'(h);
      exp_sensor(t, h);
      run_tick(1'b0, 2'b00);
      wait_frames(1, 2000);
      check_stream("rand_sensor");
    end

    // second tie after a sensor frame: ack wins
    t = $urandom_range(0, 255);
    h = $urandom_range(0, 255);
    rc = 2'($urandom_range(0, 3));
    temperature = 8'(t);
    humidity = 8'(h);
    exp_ack(rc);
    exp_sensor(t, h);
    run_tick(1'b1, rc);
    check("tie2_report_pending", 32'(report_pending), 32'd1);
    wait_frames(2, 2000);
    check_stream("tie2");

    // coalesced acks during a sensor frame, then a request in the ack grant cycle
    rc = 2'($urandom_range(0, 3));
    exp_sensor(t, h);
    exp_ack(2'b11);
    exp_ack(rc);
    run_tick(1'b0, 2'b00);
    for (int k = 0; k < 3; k++) begin
      repeat (9) step();
      ack_req = 1'b1;
      ack_code = (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11;
      step();
      ack_req = 1'b0;
      check("coalesce_pending", 32'(ack_pending), 32'd1);
    end
    wait_frames(1, 2000);
    step();
    ack_req = 1'b1;
    ack_code = rc;
    step();
    ack_req = 1'b0;
    check("set_wins_pending", 32'(ack_pending), 32'd1);
    wait_frames(3, 3000);
    check_stream("coalesce");

    // overrun: transmitter stalls across three report periods
    exp_sensor(t, h);
    exp_sensor(t, h);
    stall = 1'b1;
    run_tick(1'b0, 2'b00);
    enable = 1'b1;
    repeat (3 * P) step();
    enable = 1'b0;
    check("overrun_drop_cnt", 32'(drop_cnt), 32'd2);
    check("overrun_pending", 32'(report_pending), 32'd1);
    stall = 1'b0;
    wait_frames(2, 3000);
    check_stream("overrun");

    // drop counter saturation
    stall = 1'b1;
    run_tick(1'b0, 2'b00);
    enable = 1'b1;
    repeat (SAT_PERIODS * P) step();
    enable = 1'b0;
    exp_drop = 2 + (SAT_PERIODS - 1);
    if (exp_drop > 255) exp_drop = 255;
    check("saturated_drop_cnt", 32'(drop_cnt), exp_drop);
    pulse_reset();

    // reset after the third byte abandons the frame
    temperature = 8'($urandom_range(0, 255));
    base = n_sends;
    run_tick(1'b0, 2'b00);
    c = 0;
    while (n_sends < base + 3 && c < 2000) begin
      step();
      c++;
    end
    check("third_byte_sent", 32'(n_sends - base), 32'd3);
    repeat (5) step();
    pulse_reset();
    base = n_sends;
    fd_base = fd_q.size();
    repeat (3 * P) step();
    check("no_send_after_reset", n_sends - base, 0);
    check("no_frame_after_reset", fd_q.size() - fd_base, 0);

    check("send_while_busy", send_busy, 0);
    check("data_unstable", unstable, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_frame_scheduler.md
# uart_frame_scheduler

Frame-level scheduler that shares the single Duplex UART transmitter between two frame sources: the periodic sensor report `S<TT><HH>\n` and the LED-command acknowledge `A:<l1><l2>\n`. It owns the period timer, builds each frame's ASCII bytes, arbitrates fairly when both frames are pending, and drives the UART's byte-level `send`/`tx_active_flag`/`tx_done_flag` handshake. It sits between the DHT11 sampling logic, the RX command decoder and the `Duplex` instance.

## Interface
- `REPORT_PERIOD_CYC`, default 100_000_000: clock cycles between sensor-report requests (1 s at 100 MHz). Legal range is ≥ 64.
- `clk_100Mhz`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `enable`  in  1  runs the period timer; when low, the timer is held at 0.
- `temperature`  in  8  binary °C, sampled at sensor-frame grant.
- `humidity`  in  8  binary %RH, sampled at sensor-frame grant.
- `ack_req`  in  1  one-cycle request for an ack frame.
- `ack_code`  in  2  LED states to echo; bit1 = led_1, bit0 = led_2. Captured with `ack_req`.
- `uart_tx_active`  in  1  from Duplex `tx_active_flag`.
- `uart_tx_done`  in  1  from Duplex `tx_done_flag`, a one-cycle pulse.
- `uart_send`  out  1  one-cycle send strobe to Duplex.
- `uart_data`  out  8  byte to Duplex `data_transmit`.
- `frame_done`  out  1  one-cycle pulse after the last byte's `uart_tx_done`.
- `frame_id`  out  1  type of the current or last frame: 0 = sensor, 1 = ack.
- `report_pending`  out  1  a sensor frame is requested and not yet granted.
- `ack_pending`  out  1  an ack frame is requested and not yet granted.
- `drop_cnt`  out  8  number of sensor requests lost to overrun; saturates at 255.

## Operation
- **Period timer**
  - Counts 0..REPORT_PERIOD_CYC-1 while `enable`=1.
  - Terminal count sets `report_pending`.
  - If `report_pending` is already 1 at terminal count, increment `drop_cnt` (saturating at 255).
- **Ack request**
  - `ack_req` sets `ack_pending` and latches `ack_code` into `ack_code_q`.
  - A repeat `ack_req` while pending coalesces: the latest code wins and nothing is counted.
- **Arbitration** (in IDLE only)
  - One flag pending: grant that frame.
  - Both pending: grant the type not served last. `last_served` resets to ack, so the sensor frame wins the first tie.
  - Grant clears that pending flag.
  - A request and a grant of the same type in the same cycle: the set wins, and a new request remains pending.
- **Frame build at grant**
  - Latch the payload into a 6-byte shadow buffer and record its length.
  - Sensor frame: 'S', tens(T), ones(T), tens(H), ones(H), 0x0A (6 bytes). T and H above 99 clamp to 99. Digits are '0'+value.
  - Ack frame: 'A', ':', '0'+ack_code_q[1], '0'+ack_code_q[0], 0x0A (5 bytes).
  - Inputs changing after grant do not affect the frame in flight.
- **FSM states:** IDLE → LOAD → ISSUE → WAIT_DONE → (ISSUE | FINISH) → IDLE.
  - **LOAD:** latch the buffer and set byte index = 0.
  - **ISSUE:** wait until `uart_tx_active`=0, then drive `uart_send`=1 for exactly one cycle with `uart_data` = buffer[index].
  - **WAIT_DONE:** wait for the `uart_tx_done` pulse; `uart_tx_active` is ignored here.
    - On `uart_tx_done` with index < len-1: increment index and go to ISSUE.
    - On `uart_tx_done` with index = len-1: go to FINISH.
    - There is no timeout.
  - **FINISH:** pulse `frame_done` and update `last_served`.
- `uart_data` stays stable from the `uart_send` cycle until the matching `uart_tx_done`.
- `enable`=0 does not abort a frame in flight or pending requests; it only stops new sensor requests.

## Timing
- **Reset values:**
  - `uart_send`=0, `uart_data`=0x00, `frame_done`=0, `frame_id`=0.
  - `report_pending`=0, `ack_pending`=0, `drop_cnt`=0.
  - Timer = 0, state = IDLE.
- **Reset mid-frame:** the frame is abandoned and no further `uart_send` is issued. The Duplex shares `rst_n`.
- **Request-to-send latency:**
  - Pending flag set in cycle N; grant at the N+1 edge (LOAD); `uart_send` high in cycle N+2, provided `uart_tx_active`=0.
- **Inter-byte latency:** the `uart_tx_done` pulse in cycle M gives `uart_send` in cycle M+1 at the earliest, delayed while `uart_tx_active`=1.
- **Frame completion:** `frame_done` is high the cycle after the last `uart_tx_done`. The next grant can occur the following cycle, so frames can run back-to-back.
- **First request after enable:** `report_pending` first sets REPORT_PERIOD_CYC cycles after `enable` rises.
- **Registered outputs:** all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **Single sensor frame:** REPORT_PERIOD_CYC=200, T=25, H=50, UART model with 20-cycle bytes → byte stream 0x53,'2','5','5','0',0x0A; exactly 6 `uart_send` pulses; `frame_done` with `frame_id`=0.
- **Tie arbitration:** `ack_req` with code 2'b10 in the same cycle as the timer tick → sensor frame first, then 'A',':','1','0',0x0A. A second tie → ack frame first.
- **Clamp and capture:** T=123, H=7, with T changed to 30 mid-frame → "S9907\n".
- **Overrun:** UART model stalls `uart_tx_done` for 3 report periods → `drop_cnt`=2 and `report_pending`=1. Saturation test: force 300 drops → `drop_cnt`=255.
- **Ack coalesce and set-wins:** three `ack_req` pulses (codes 00, 01, 11) during a sensor frame → one ack frame "A:11\n". `ack_req` in the grant cycle → a second ack frame follows.
- **Reset mid-frame:** `rst_n`=0 for 1 cycle after byte 3 → all outputs at reset values the next cycle; no `uart_send` until a new request.
